// File: rtl/aes_round_engine_pkg.sv
// ============================================================================
// | Module      : AESDefinitions (package)                                   |
// | Description : Shared AES types, round count and GF(2^8) byte helpers.    |
// | Revision    : 1.0 - initial release                                      |
// ============================================================================
`default_nettype none

package AESDefinitions;

    typedef logic [127:0] state_t;
    typedef logic [127:0] roundKey_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fsm_t;

    function automatic int numRounds(input int keyWords);
        return keyWords + 6;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254 (square-and-multiply); maps 0 to 0.
    function automatic logic [7:0] gfInv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] x;
        r = 8'h01;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (i != 0) r = gfMul(r, x);
            x = gfMul(x, x);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] a, input int n);
        logic [15:0] d;
        d = {a, a} << n;
        return d[15:8];
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] i;
        i = gfInv(a);
        return i ^ rotl8(i, 1) ^ rotl8(i, 2) ^ rotl8(i, 3) ^ rotl8(i, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] invSbox(input logic [7:0] s);
        return gfInv(rotl8(s, 1) ^ rotl8(s, 3) ^ rotl8(s, 6) ^ 8'h05);
    endfunction

endpackage

`default_nettype wire

// File: rtl/aes_round_engine_round_unit.sv
// ============================================================================
// | Module      : aes_round_unit                                             |
// | Description : Combinational forward / inverse AES round.                 |
// | Revision    : 1.0 - initial release                                      |
// ============================================================================
`default_nettype none

module aes_round_unit
    import AESDefinitions::*;
(
    input  logic [127:0] state_i,
    input  logic [127:0] roundKey_i,
    input  logic         decrypt_i,
    input  logic         lastRound_i,
    output logic [127:0] state_o
);

    logic [7:0] w_in   [16];
    logic [7:0] w_key  [16];
    logic [7:0] w_sub  [16];
    logic [7:0] w_pre  [16];
    logic [7:0] w_mix  [16];
    logic [7:0] w_post [16];
    logic [7:0] w_c    [4];

    // Byte k = row + 4*column, byte 0 in the top bits of the block.
    always_comb begin
        state_o = '0;
        for (int k = 0; k < 16; k++) begin
            w_in[k]  = state_i[127-8*k -: 8];
            w_key[k] = roundKey_i[127-8*k -: 8];
        end
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                w_sub[r+4*c] = decrypt_i ? invSbox(w_in[r+4*((c+4-r)%4)])
                                         : sbox(w_in[r+4*((c+r)%4)]);
            end
        end
        // Inverse round adds the key before InvMixColumns, forward round after MixColumns.
        for (int k = 0; k < 16; k++) begin
            w_pre[k] = decrypt_i ? (w_sub[k] ^ w_key[k]) : w_sub[k];
        end
        w_c[0] = decrypt_i ? 8'h0e : 8'h02;
        w_c[1] = decrypt_i ? 8'h0b : 8'h03;
        w_c[2] = decrypt_i ? 8'h0d : 8'h01;
        w_c[3] = decrypt_i ? 8'h09 : 8'h01;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                w_mix[r+4*c] = gfMul(w_c[0], w_pre[4*c+r])
                             ^ gfMul(w_c[1], w_pre[4*c+((r+1)%4)])
                             ^ gfMul(w_c[2], w_pre[4*c+((r+2)%4)])
                             ^ gfMul(w_c[3], w_pre[4*c+((r+3)%4)]);
            end
        end
        for (int k = 0; k < 16; k++) begin
            w_post[k] = lastRound_i ? w_pre[k] : w_mix[k];
            state_o[127-8*k -: 8] = decrypt_i ? w_post[k] : (w_post[k] ^ w_key[k]);
        end
    end

endmodule

`default_nettype wire

// File: rtl/aes_round_engine.sv
// ============================================================================
// | Module      : aes_round_engine                                           |
// | Description : Iterative AES block engine, one round per clock.           |
// |               Define AES_ROUND_TRACE_EN to add traceRound/traceState.    |
// | Revision    : 1.0 - initial release                                      |
// ============================================================================
`default_nettype none

module aes_round_engine
    import AESDefinitions::*;
#(
    parameter int KEY_WORDS = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         inValid,
    output logic         inReady,
    input  logic [127:0] inData,
    input  logic         inDecrypt,
    output logic [3:0]   keyIndex,
    input  logic [127:0] roundKey,
    output logic         outValid,
    input  logic         outReady,
    output logic [127:0] outData
`ifdef AES_ROUND_TRACE_EN
    ,
    output logic [3:0]   traceRound,
    output logic [127:0] traceState
`endif
);

    if (KEY_WORDS != 4 && KEY_WORDS != 6 && KEY_WORDS != 8) begin : g_bad_key_words
        $error("aes_round_engine: KEY_WORDS must be 4, 6 or 8");
    end

    localparam logic [3:0] c_NR = 4'(numRounds(KEY_WORDS));

    fsm_t       fsm_q;
    logic [3:0] cnt_q;
    state_t     data_q;
    state_t     data_d;
    state_t     w_roundOut;
    logic       dec_q;
    logic [3:0] keyIndex_q;
    logic       outValid_q;
    logic       inReady_q;

    aes_round_unit u_round (
        .state_i     (data_q),
        .roundKey_i  (roundKey),
        .decrypt_i   (dec_q),
        .lastRound_i (cnt_q == c_NR),
        .state_o     (w_roundOut)
    );

    // The first RUN cycle is the initial AddRoundKey only.
    assign data_d = (cnt_q == 4'd0) ? (data_q ^ roundKey) : w_roundOut;

    always_ff @(posedge clock) begin
        if (reset) begin
            fsm_q      <= IDLE;
            cnt_q      <= 4'd0;
            data_q     <= '0;
            dec_q      <= 1'b0;
            keyIndex_q <= 4'd0;
            outValid_q <= 1'b0;
            inReady_q  <= 1'b1;
        end else begin
            case (fsm_q)
                IDLE: begin
                    if (inValid && inReady_q) begin
                        data_q     <= inData;
                        dec_q      <= inDecrypt;
                        cnt_q      <= 4'd0;
                        keyIndex_q <= inDecrypt ? c_NR : 4'd0;
                        inReady_q  <= 1'b0;
                        fsm_q      <= RUN;
                    end
                end
                RUN: begin
                    data_q <= data_d;
                    if (cnt_q == c_NR) begin
                        keyIndex_q <= 4'd0;
                        outValid_q <= 1'b1;
                        fsm_q      <= DONE;
                    end else begin
                        cnt_q      <= cnt_q + 4'd1;
                        keyIndex_q <= dec_q ? (c_NR - cnt_q - 4'd1) : (cnt_q + 4'd1);
                    end
                end
                DONE: begin
                    if (outReady) begin
                        cnt_q      <= 4'd0;
                        outValid_q <= 1'b0;
                        inReady_q  <= 1'b1;
                        fsm_q      <= IDLE;
                    end
                end
                default: begin
                    fsm_q <= IDLE;
                end
            endcase
        end
    end

    assign inReady  = inReady_q;
    assign keyIndex = keyIndex_q;
    assign outValid = outValid_q;
    assign outData  = data_q;

`ifdef AES_ROUND_TRACE_EN
    assign traceRound = cnt_q;
    assign traceState = data_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_aes_round_engine.sv
// ============================================================================
// | Module      : tb_aes_round_engine                                        |
// | Description : Scoreboard bench for KEY_WORDS 4/6/8 engine instances.     |
// | Revision    : 1.0 - initial release                                      |
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_aes_round_engine;

    localparam logic [127:0] c_PT    = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] c_CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] c_CT192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] c_CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;

    logic         clock = 1'b0;
    logic         reset;
    logic         inValid   [3];
    logic         inReady   [3];
    logic [127:0] inData    [3];
    logic         inDecrypt [3];
    logic [3:0]   keyIndex  [3];
    logic [127:0] roundKey  [3];
    logic         outValid  [3];
    logic         outReady  [3];
    logic [127:0] outData   [3];
`ifdef AES_ROUND_TRACE_EN
    logic [3:0]   traceRound [3];
    logic [127:0] traceState [3];
`endif

    logic [127:0] rk_tab [3][16];
    logic [7:0]   sbox_t [256];
    logic [127:0] sb_q [$];
    int           n_tests = 0;
    int           n_fail  = 0;

    always #5 clock = ~clock;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        assign roundKey[g] = rk_tab[g][keyIndex[g]];
        aes_round_engine #(.KEY_WORDS(4 + 2*g)) u_dut (
            .clock     (clock),
            .reset     (reset),
            .inValid   (inValid[g]),
            .inReady   (inReady[g]),
            .inData    (inData[g]),
            .inDecrypt (inDecrypt[g]),
            .keyIndex  (keyIndex[g]),
            .roundKey  (roundKey[g]),
            .outValid  (outValid[g]),
            .outReady  (outReady[g]),
            .outData   (outData[g])
`ifdef AES_ROUND_TRACE_EN
            ,
            .traceRound (traceRound[g]),
            .traceState (traceState[g])
`endif
        );
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] want);
        n_tests++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, want);
        end
    endtask

    // S-box built from the generator-3 walk, independent of the design's arithmetic.
    task automatic build_sbox();
        logic [7:0] p;
        logic [7:0] q;
        logic [7:0] x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b0};
            q = q ^ {q[3:0], 4'b0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            sbox_t[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sbox_t[0] = 8'h63;
    endtask

    task automatic expand_key(input int u, input logic [255:0] key);
        int          nk;
        int          nr;
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rcon;
        nk   = 4 + 2*u;
        nr   = nk + 6;
        rcon = 8'h01;
        for (int i = 0; i < 4*(nr+1); i++) begin
            if (i < nk) begin
                w[i] = key[255-32*i -: 32];
            end else begin
                t = w[i-1];
                if (i % nk == 0) begin
                    t = {sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]], sbox_t[t[31:24]]}
                        ^ {rcon, 24'h0};
                    rcon = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
                end else if (nk > 6 && i % nk == 4) begin
                    t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
                end
                w[i] = w[i-nk] ^ t;
            end
        end
        for (int r = 0; r <= nr; r++) begin
            rk_tab[u][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        end
    endtask

    function automatic logic [255:0] seq_key(input int nk);
        logic [255:0] k;
        k = '0;
        for (int b = 0; b < 4*nk; b++) k[255-8*b -: 8] = 8'(b);
        return k;
    endfunction

    task automatic run_block(input int u, input logic [127:0] din, input logic dec,
                             input logic [127:0] want, input int hold);
        int           nr;
        int           e;
        logic [127:0] got;
        nr = 10 + 2*u;
        e  = 0;
        while (!inReady[u] && e < 50) begin
            tick();
            e++;
        end
        check_eq("in_ready", 128'(inReady[u]), 128'd1);
        inData[u]    = din;
        inDecrypt[u] = dec;
        inValid[u]   = 1'b1;
        sb_q.push_back(want);
        tick();
        inValid[u]   = 1'b0;
        inData[u]    = ~din;
        inDecrypt[u] = ~dec;
        e = 0;
        while (!outValid[u] && e < 40) begin
            check_eq("key_index", 128'(keyIndex[u]), 128'(dec ? nr - e : e));
            check_eq("busy_ready", 128'(inReady[u]), 128'd0);
            tick();
            e++;
        end
        check_eq("latency", 128'(e), 128'(nr + 1));
        check_eq("sb_depth", 128'(sb_q.size()), 128'd1);
        if (sb_q.size() != 0) begin
            got = sb_q.pop_front();
            check_eq("out_data", outData[u], got);
            for (int h = 0; h < hold; h++) begin
                inValid[u] = 1'b1;
                tick();
                check_eq("hold_valid", 128'(outValid[u]), 128'd1);
                check_eq("hold_data", outData[u], got);
                check_eq("hold_ready", 128'(inReady[u]), 128'd0);
            end
        end
        inValid[u]  = 1'b0;
        outReady[u] = 1'b1;
        tick();
        outReady[u] = 1'b0;
        check_eq("ret_valid", 128'(outValid[u]), 128'd0);
        check_eq("ret_ready", 128'(inReady[u]), 128'd1);
        check_eq("ret_key", 128'(keyIndex[u]), 128'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        for (int u = 0; u < 3; u++) begin
            inValid[u]   = 1'b0;
            inData[u]    = '0;
            inDecrypt[u] = 1'b0;
            outReady[u]  = 1'b0;
        end
        build_sbox();
        for (int u = 0; u < 3; u++) expand_key(u, seq_key(4 + 2*u));
        tick();
        tick();
        for (int u = 0; u < 3; u++) begin
            check_eq("rst_ready", 128'(inReady[u]), 128'd1);
            check_eq("rst_valid", 128'(outValid[u]), 128'd0);
            check_eq("rst_key", 128'(keyIndex[u]), 128'd0);
            check_eq("rst_data", outData[u], 128'd0);
        end
        reset = 1'b0;

        run_block(0, c_PT, 1'b0, c_CT128, 0);
        run_block(0, c_CT128, 1'b1, c_PT, 0);
        run_block(1, c_PT, 1'b0, c_CT192, 0);
        run_block(1, c_CT192, 1'b1, c_PT, 0);
        run_block(2, c_PT, 1'b0, c_CT256, 2);
        run_block(2, c_CT256, 1'b1, c_PT, 0);
        run_block(0, c_PT, 1'b0, c_CT128, 5);
        tick();
        check_eq("bp_idle_valid", 128'(outValid[0]), 128'd0);
        check_eq("bp_idle_key", 128'(keyIndex[0]), 128'd0);

        // Abort a block at cnt=5; it must never reach the output.
        inData[0]    = c_PT;
        inDecrypt[0] = 1'b0;
        inValid[0]   = 1'b1;
        tick();
        inValid[0] = 1'b0;
        repeat (5) tick();
        check_eq("mid_key", 128'(keyIndex[0]), 128'd5);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_eq("abort_valid", 128'(outValid[0]), 128'd0);
        check_eq("abort_ready", 128'(inReady[0]), 128'd1);
        check_eq("abort_key", 128'(keyIndex[0]), 128'd0);
        check_eq("abort_data", outData[0], 128'd0);
        run_block(0, c_CT128, 1'b1, c_PT, 0);
        check_eq("sb_final", 128'(sb_q.size()), 128'd0);

`ifdef AES_ROUND_TRACE_EN
        expand_key(0, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0});
        inData[0]    = 128'h3243f6a8885a308d313198a2e0370734;
        inDecrypt[0] = 1'b0;
        inValid[0]   = 1'b1;
        tick();
        inValid[0] = 1'b0;
        for (int e = 0; e <= 10; e++) begin
            check_eq("trace_round", 128'(traceRound[0]), 128'(e));
            if (e == 1) check_eq("trace_r1", traceState[0], 128'h193de3bea0f4e22b9ac68d2ae9f84808);
            if (e == 2) check_eq("trace_r2", traceState[0], 128'ha49c7ff2689f352b6b5bea43026a5049);
            tick();
        end
        check_eq("trace_done", traceState[0], 128'h3925841d02dc09fbdc118597196a0b32);
        check_eq("trace_valid", 128'(outValid[0]), 128'd1);
        outReady[0] = 1'b1;
        tick();
        outReady[0] = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/aes_round_engine.md
AES_ROUND_ENGINE -- requirements
Module: aes_round_engine

Interface
REQ-001 SHALL have parameter KEY_WORDS, default 4, which is the cipher key length in 32-bit words. Legal values are 4, 6 and 8, selecting NR = 10, 12 or 14 rounds.
REQ-002 SHALL have port clock  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port inValid  input  1  a block is offered.
REQ-005 SHALL have port inReady  output  1  the engine can accept a block.
REQ-006 SHALL have port inData  input  128  plaintext or ciphertext block.
REQ-007 SHALL have port inDecrypt  input  1  direction, sampled at accept: 1 = inverse cipher.
REQ-008 SHALL have port keyIndex  output  4  index of the round key needed this cycle.
REQ-009 SHALL have port roundKey  input  128  round key for keyIndex, valid combinationally in the same cycle.
REQ-010 SHALL have port outValid  output  1  a result is held.
REQ-011 SHALL have port outReady  input  1  the consumer accepts the result.
REQ-012 SHALL have port outData  output  128  result block.

Function
REQ-013 SHALL implement an FSM with three states, IDLE, RUN and DONE; inReady is high only in IDLE.
REQ-014 SHALL accept a block when inValid and inReady are both high at a rising edge. At that edge it latches inData into the state register, latches inDecrypt, clears round counter cnt to 0 and moves to RUN.
REQ-015 SHALL drive keyIndex in RUN as cnt for encrypt and NR-cnt for decrypt, and SHALL drive keyIndex to 0 in IDLE and DONE.
REQ-016 SHALL apply the following each RUN edge: cnt==0 applies AddRoundKey only; 0<cnt<NR applies a full round (forward or inverse per FIPS-197); cnt==NR applies the final round without (Inv)MixColumns and moves to DONE. cnt increments by 1 on each RUN edge.
REQ-017 SHALL assert outValid first NR+1 cycles after the accept edge, i.e. 11, 13 and 15 cycles for KEY_WORDS 4, 6 and 8.
REQ-018 SHALL, in DONE, hold outValid=1 and outData=state register stable until outReady is high at an edge, then return to IDLE.
REQ-019 SHALL leave a minimum gap of one idle cycle between blocks; an inValid arriving while in RUN or DONE is not accepted and has no effect.
REQ-020 SHALL ignore changes on inData and inDecrypt after the accept edge.
REQ-021 SHALL size cnt at 4 bits; cnt never exceeds NR and does not wrap.
REQ-022 SHALL raise an elaboration-time error when KEY_WORDS is not 4, 6 or 8.

Reset
REQ-023 SHALL set the following on reset, taking priority over all other activity including mid-RUN: FSM=IDLE, cnt=0, state register=0, outValid=0, inReady=1 (the cycle after the reset edge), outData=0, keyIndex=0.
REQ-024 SHALL discard any in-flight block on reset; it is never output.

Configuration
REQ-025 SHALL, when macro AES_ROUND_TRACE_EN is defined, add output ports traceRound (4 bits, equals cnt) and traceState (128 bits, equals the state register), both valid every cycle and 0 under reset.
REQ-026 SHALL, without AES_ROUND_TRACE_EN, omit those ports and their logic; all other behaviour is identical.

Structure
REQ-027 SHALL take state_t and roundKey_t (128-bit) and the function numRounds(KEY_WORDS) from the shared package AESDefinitions.
REQ-028 SHALL contain one combinational sub-module, aes_round_unit. Its inputs are state, roundKey, decrypt and a lastRound flag; it performs the forward or inverse round. The engine contains only the FSM, the counter and the registers.

Verification
REQ-029 SHALL cover AES-128 encrypt: in=00112233445566778899AABBCCDDEEFF, key=000102...0F -> outData=69C4E0D86A7B0430D8CDB78070B4C55A, outValid 11 cycles after accept.
REQ-030 SHALL cover AES-128 decrypt: in=69C4E0D86A7B0430D8CDB78070B4C55A with the same key schedule -> 00112233445566778899AABBCCDDEEFF, with keyIndex sequence 10,9,...,0.
REQ-031 SHALL cover KEY_WORDS=6 with key 000102...17 -> DDA97CA4864CDFE06EAF70A0EC0D7191 after 13 cycles, and KEY_WORDS=8 with key 000102...1F -> 8EA2B7CA516745BFEAFC49904B496089 after 15 cycles.
REQ-032 SHALL cover backpressure: outReady held low 5 cycles in DONE -> outValid and outData stable, inReady=0 throughout, a new inValid is ignored.
REQ-033 SHALL cover reset asserted at cnt=5 -> next cycle outValid=0, inReady=1, keyIndex=0; a following block completes correctly.
REQ-034 SHALL cover a build with AES_ROUND_TRACE_EN: traceRound steps 0..NR while in RUN and traceState matches the FIPS-197 Appendix B intermediate rows.
